axi_read_responder: RTL and testbench

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder_pkg.sv | 19 +
 rtl/axi_read_responder_if.sv | 29 ++
 rtl/axi_read_responder_ar_fifo.sv | 59 +++++
 rtl/axi_read_responder.sv | 160 ++++++++++++++++
 tb/tb_axi_read_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_read_responder_pkg.sv
// Shared constants, FSM state type and request-width helpers for the AXI read responder.
package axi_read_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AR_LEN_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Packed AR request layout in the queue is {id, len, addr}.
    function automatic int ar_req_width(input int addr_width, input int id_width);
        return addr_width + AR_LEN_WIDTH + id_width;
    endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AR/R channel bundle for the AXI read responder; master drives requests, slave returns data.
interface axi_read_responder_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ID_WIDTH   = 1
);
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [C_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic [C_ID_WIDTH-1:0]   s_axi_arid;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [C_DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic [C_ID_WIDTH-1:0]   s_axi_rid;

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arid, s_axi_rready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid
    );

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_arid, s_axi_rready,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid
    );

endinterface

// File: rtl/axi_read_responder_ar_fifo.sv
// Synchronous in-order queue of accepted AR requests with full/empty flags.
module axi_read_responder_ar_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // NOTE: the storage array is deliberately not reset; count gates every read,
    // so stale entries are never observed and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_idx(wr_ptr);
            if (do_pop)  rd_ptr <= next_idx(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI INCR read responder returning each beat's address as data, bursts served in order.
// Optional feature: define AXI_READ_RESPONDER_ERR_EN to flag bursts starting at or above C_MEM_BYTES with SLVERR.
module axi_read_responder
    import axi_read_responder_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_ID_WIDTH        = 1,
    parameter int C_MAX_OUTSTANDING = 4,
    parameter int C_MEM_BYTES       = 65536
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    axi_read_responder_if.slave                    s_axi,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                   idle
);

    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int REQ_W      = ar_req_width(C_ADDR_WIDTH, C_ID_WIDTH);
    localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
    localparam int EXT_W      = (C_ADDR_WIDTH > C_DATA_WIDTH) ? C_ADDR_WIDTH : C_DATA_WIDTH;

    state_e                  state_q, state_d;
    logic                    pop;
    logic                    advance;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [REQ_W-1:0]        head;
    logic [C_ADDR_WIDTH-1:0] head_addr;
    logic [7:0]              head_len;
    logic [C_ID_WIDTH-1:0]   head_id;

    logic [C_ADDR_WIDTH-1:0] cur_addr_q;
    logic [7:0]              beat_cnt_q;
    logic [C_ID_WIDTH-1:0]   cur_id_q;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;
    logic                    arready_q;
    logic                    rvalid;
    logic                    rlast;
    logic                    ar_hs;
    logic                    last_hs;
    logic [EXT_W-1:0]        addr_ext;

    assign ar_hs   = s_axi.s_axi_arvalid & arready_q;
    assign rvalid  = (state_q == BURST);
    assign rlast   = rvalid & (beat_cnt_q == '0);
    assign last_hs = rvalid & s_axi.s_axi_rready & rlast;

    axi_read_responder_ar_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (C_MAX_OUTSTANDING)
    ) u_ar_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data ({s_axi.s_axi_arid, s_axi.s_axi_arlen, s_axi.s_axi_araddr}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_id, head_len, head_addr} = head;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (s_axi.s_axi_rready) begin
                    if (beat_cnt_q == '0) begin
                        // Back-to-back bursts reload on the last beat without a bubble.
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            cur_id_q   <= '0;
        end else if (pop) begin
            cur_addr_q <= head_addr;
            beat_cnt_q <= head_len;
            cur_id_q   <= head_id;
        end else if (advance) begin
            cur_addr_q <= cur_addr_q + C_ADDR_WIDTH'(BEAT_BYTES);
            beat_cnt_q <= beat_cnt_q - 8'd1;
        end
    end

`ifdef AXI_READ_RESPONDER_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (pop) begin
            err_q <= (64'(head_addr) >= 64'(C_MEM_BYTES));
        end
    end

    assign s_axi.s_axi_rresp = err_q ? RESP_SLVERR : RESP_OKAY;
`else
    assign s_axi.s_axi_rresp = RESP_OKAY;
`endif

    // The burst in flight counts as outstanding until its last beat is taken.
    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !last_hs)      outstanding_d = outstanding_q + OUT_W'(1);
        else if (!ar_hs && last_hs) outstanding_d = outstanding_q - OUT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            arready_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            arready_q     <= (outstanding_d < OUT_W'(C_MAX_OUTSTANDING));
        end
    end

    assign addr_ext = EXT_W'(cur_addr_q);

    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rlast   = rlast;
    assign s_axi.s_axi_rdata   = addr_ext[C_DATA_WIDTH-1:0];
    assign s_axi.s_axi_rid     = cur_id_q;
    assign outstanding         = outstanding_q;
    assign idle                = (outstanding_q == '0);

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed steps plus random traffic against a beat-queue model.
module tb_axi_read_responder;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 1;
    localparam int MAXO = 4;
    localparam int MEMB = 65536;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] outstanding;
    logic       idle;

    always #5 clk = ~clk;

    axi_read_responder_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW)) bus ();

    axi_read_responder #(
        .C_ADDR_WIDTH      (AW),
        .C_DATA_WIDTH      (DW),
        .C_ID_WIDTH        (IW),
        .C_MAX_OUTSTANDING (MAXO),
        .C_MEM_BYTES       (MEMB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axi       (bus.slave),
        .outstanding (outstanding),
        .idle        (idle)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } beat_t;

    beat_t exp_q[$];
    beat_t held;
    int    model_out;
    int    n_assert;
    int    n_fail;
    int    beats_seen;
    logic  stalled;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expand an accepted request into the beats the spec says it must produce.
    task automatic model_accept(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            b.data = DW'(addr + AW'(i * (DW / 8)));
            b.last = (i == int'(len));
            b.id   = id;
            b.resp = 2'b00;
`ifdef AXI_READ_RESPONDER_ERR_EN
            if (64'(addr) >= 64'(MEMB)) b.resp = 2'b10;
`endif
            exp_q.push_back(b);
        end
        model_out++;
    endtask

    // One clock cycle: drive at negedge, score handshakes at the coming posedge, check status after it.
    task automatic cycle(input logic av, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id, input logic rr);
        logic  ar_hs;
        logic  r_hs;
        beat_t e;
        bus.s_axi_arvalid = av;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arid    = id;
        bus.s_axi_rready  = rr;
        if (stalled) begin
            check("hold_rvalid", bus.s_axi_rvalid, 1);
            check("hold_rdata", bus.s_axi_rdata, held.data);
            check("hold_rlast", bus.s_axi_rlast, held.last);
            check("hold_rid", bus.s_axi_rid, held.id);
            check("hold_rresp", bus.s_axi_rresp, held.resp);
        end
        check("rvalid_without_request", bus.s_axi_rvalid && (exp_q.size() == 0), 0);
        ar_hs = av && bus.s_axi_arready;
        r_hs  = bus.s_axi_rvalid && rr;
        if (r_hs && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rdata", bus.s_axi_rdata, e.data);
            check("rlast", bus.s_axi_rlast, e.last);
            check("rid", bus.s_axi_rid, e.id);
            check("rresp", bus.s_axi_rresp, e.resp);
            if (e.last) model_out--;
            beats_seen++;
        end
        stalled = bus.s_axi_rvalid && !rr;
        if (stalled) begin
            held.data = bus.s_axi_rdata;
            held.last = bus.s_axi_rlast;
            held.id   = bus.s_axi_rid;
            held.resp = bus.s_axi_rresp;
        end
        if (ar_hs) model_accept(addr, len, id);
        @(negedge clk);
        check("outstanding", outstanding, model_out);
        check("idle", idle, model_out == 0);
        check("arready", bus.s_axi_arready, model_out < MAXO);
    endtask

    task automatic drain(input bit random_rr, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle(1'b0, '0, '0, '0, random_rr ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        model_out  = 0;
        beats_seen = 0;
        stalled    = 1'b0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arid    = '0;
        bus.s_axi_rready  = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arready", bus.s_axi_arready, 0);
        check("rst_rvalid", bus.s_axi_rvalid, 0);
        check("rst_rlast", bus.s_axi_rlast, 0);
        check("rst_rdata", bus.s_axi_rdata, 0);
        check("rst_rresp", bus.s_axi_rresp, 0);
        check("rst_rid", bus.s_axi_rid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;
        check("arready_before_first_edge", bus.s_axi_arready, 0);
        @(negedge clk);
        check("arready_after_first_edge", bus.s_axi_arready, 1);

        // Basic 4-beat burst and first-beat latency
        cycle(1'b1, 32'h100, 8'd3, 1'b0, 1'b1);
        check("latency_edge_k", bus.s_axi_rvalid, 0);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("latency_edge_k1", bus.s_axi_rvalid, 1);
        drain(1'b0, 50);

        // Outstanding limit: five requests with the R channel stalled
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, AW'(32'h200 + 16 * i), 8'd0, 1'b0, 1'b0);
        end
        check("accepted_limit", model_out, 4);
        check("arready_full", bus.s_axi_arready, 0);
        check("outstanding_full", outstanding, 4);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("arready_after_one_done", bus.s_axi_arready, 1);
        drain(1'b0, 50);

        // Two queued single-beat bursts come out without a gap
        cycle(1'b1, 32'h300, 8'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h400, 8'd0, 1'b1, 1'b0);
        check("b2b_first_valid", bus.s_axi_rvalid, 1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("b2b_no_gap", bus.s_axi_rvalid, 1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("b2b_done", bus.s_axi_rvalid, 0);

        // Random backpressure over an 8-beat burst
        beats_seen = 0;
        cycle(1'b1, AW'($urandom & 32'h0000_FFFC), 8'd7, 1'($urandom_range(0, 1)), 1'b0);
        drain(1'b1, 300);
        check("stall_beat_count", beats_seen, 8);
        check("stall_end_outstanding", outstanding, 0);
        check("stall_end_idle", idle, 1);

        // Address wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFF8, 8'd3, 1'b1, 1'b1);
        drain(1'b0, 50);

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom & 32'h0001_FFFC), 8'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain(1'b1, 600);

        // Reset asserted on beat 2 of an 8-beat burst with a second request queued
        cycle(1'b1, 32'h2000, 8'd7, 1'b0, 1'b0);
        cycle(1'b1, 32'h3000, 8'd2, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("pre_reset_beat2", bus.s_axi_rdata, 32'h2008);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", bus.s_axi_rvalid, 0);
        check("midrst_outstanding", outstanding, 0);
        check("midrst_idle", idle, 1);
        check("midrst_arready", bus.s_axi_arready, 0);
        exp_q.delete();
        model_out = 0;
        stalled   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_arready", bus.s_axi_arready, 1);
        check("post_rst_rvalid", bus.s_axi_rvalid, 0);
        cycle(1'b1, 32'h500, 8'd1, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("post_rst_no_stale_burst", bus.s_axi_rdata, 32'h500);
        drain(1'b0, 50);

`ifdef AXI_READ_RESPONDER_ERR_EN
        // Out-of-range start address returns SLVERR on every beat
        beats_seen = 0;
        cycle(1'b1, AW'(MEMB), 8'd1, 1'b0, 1'b1);
        drain(1'b0, 50);
        check("err_beat_count", beats_seen, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
